// File: rtl/dma_reg_prog.sv
// rtl/dma_reg_prog.sv - DMA controller CPU register file with byte-pointer access
module dma_reg_prog (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS_N,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic [3:0]  A,
    input  logic [7:0]  DBIn,
    output logic [7:0]  DBOut,
    output logic        DBOe,
    input  logic        updEn,
    input  logic [1:0]  updChan,
    input  logic [15:0] updAddr,
    input  logic [15:0] updWord,
    input  logic        reloadEn,
    input  logic [1:0]  reloadChan,
    input  logic [3:0]  tc,
    input  logic [3:0]  dreq,
    input  logic        tempLoad,
    input  logic [7:0]  tempIn,
    output logic [15:0] currAddrReg [0:3],
    output logic [15:0] currWordReg [0:3],
    output logic [15:0] baseAddrReg [0:3],
    output logic [15:0] baseWordReg [0:3],
    output logic [5:0]  modeReg     [0:3],
    output logic [7:0]  commandReg,
    output logic [7:0]  requestReg,
    output logic [7:0]  maskReg,
    output logic [7:0]  tempReg,
    output logic [7:0]  statusReg
);

    logic        r_iow_n_q, r_rd_act_q, r_ff, r_dboe;
    logic [3:0]  r_rd_addr_q;
    logic [7:0]  r_dbout, r_cmd, r_req, r_mask, r_temp, r_status;
    logic [15:0] r_curr_addr [0:3];
    logic [15:0] r_curr_word [0:3];
    logic [15:0] r_base_addr [0:3];
    logic [15:0] r_base_word [0:3];
    logic [5:0]  r_mode      [0:3];

    logic        w_wr, w_rd, w_rd_end, w_mc, w_stat_clr, w_ff;
    logic [1:0]  w_ch;
    logic [7:0]  w_rd_data, w_cmd, w_req, w_mask, w_temp, w_status;
    logic [15:0] w_sel16;
    logic [15:0] w_curr_addr [0:3];
    logic [15:0] w_curr_word [0:3];
    logic [15:0] w_base_addr [0:3];
    logic [15:0] w_base_word [0:3];
    logic [5:0]  w_mode      [0:3];

    // Write commits only on the falling edge of IOW_N; all three strobes low is neither read nor write.
    assign w_wr       = !CS_N && !IOW_N && IOR_N && r_iow_n_q;
    assign w_rd       = !CS_N && !IOR_N && IOW_N;
    assign w_rd_end   = r_rd_act_q && IOR_N;
    assign w_ch       = A[2:1];
    assign w_mc       = w_wr && (A == 4'hD);
    assign w_stat_clr = w_mc || (w_rd_end && (r_rd_addr_q == 4'h8));
    assign w_status   = {dreq, ((w_stat_clr ? 4'h0 : r_status[3:0]) | tc)};

    always_comb begin
        w_curr_addr = r_curr_addr;
        w_curr_word = r_curr_word;
        w_base_addr = r_base_addr;
        w_base_word = r_base_word;
        for (int n = 0; n < 4; n++) begin
            if (updEn && (updChan == n[1:0])) begin
                w_curr_addr[n] = updAddr;
                w_curr_word[n] = updWord;
            end
            if (reloadEn && (reloadChan == n[1:0])) begin
                w_curr_addr[n] = r_base_addr[n];
                w_curr_word[n] = r_base_word[n];
            end
        end
        // CPU byte write is applied last so it overrides only the byte it touches.
        if (w_wr && !A[3]) begin
            if (!A[0]) begin
                if (r_ff) begin
                    w_base_addr[w_ch][15:8] = DBIn;
                    w_curr_addr[w_ch][15:8] = DBIn;
                end else begin
                    w_base_addr[w_ch][7:0] = DBIn;
                    w_curr_addr[w_ch][7:0] = DBIn;
                end
            end else begin
                if (r_ff) begin
                    w_base_word[w_ch][15:8] = DBIn;
                    w_curr_word[w_ch][15:8] = DBIn;
                end else begin
                    w_base_word[w_ch][7:0] = DBIn;
                    w_curr_word[w_ch][7:0] = DBIn;
                end
            end
        end
    end

    always_comb begin
        w_cmd  = r_cmd;
        w_req  = r_req;
        w_mask = r_mask;
        w_mode = r_mode;
        w_temp = tempLoad ? tempIn : r_temp;
        w_ff   = r_ff ^ (w_wr && !A[3]) ^ (w_rd_end && !r_rd_addr_q[3]);
        if (w_wr) begin
            case (A)
                4'h8: w_cmd = DBIn;
                4'h9: w_req[{1'b0, DBIn[1:0]}] = DBIn[2];
                4'hA: w_mask[{1'b0, DBIn[1:0]}] = DBIn[2];
                4'hB: w_mode[DBIn[1:0]] = DBIn[7:2];
                4'hC: w_ff = 1'b0;
                4'hE: w_mask = 8'h00;
                4'hF: w_mask = {4'h0, DBIn[3:0]};
                default: ;
            endcase
        end
        if (w_mc) begin
            w_cmd  = 8'h00;
            w_req  = 8'h00;
            w_temp = 8'h00;
            w_mask = 8'h0F;
            w_ff   = 1'b0;
        end
    end

    always_comb begin
        w_sel16   = A[0] ? r_curr_word[w_ch] : r_curr_addr[w_ch];
        w_rd_data = 8'h00;
        if (!A[3])
            w_rd_data = r_ff ? w_sel16[15:8] : w_sel16[7:0];
        else if (A == 4'h8)
            w_rd_data = r_status;
        else if (A == 4'hD)
            w_rd_data = r_temp;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int n = 0; n < 4; n++) begin
                r_curr_addr[n] <= 16'h0000;
                r_curr_word[n] <= 16'h0000;
                r_base_addr[n] <= 16'h0000;
                r_base_word[n] <= 16'h0000;
                r_mode[n]      <= 6'h00;
            end
            r_cmd       <= 8'h00;
            r_req       <= 8'h00;
            r_mask      <= 8'h0F;
            r_temp      <= 8'h00;
            r_status    <= 8'h00;
            r_ff        <= 1'b0;
            r_iow_n_q   <= 1'b0;
            r_rd_act_q  <= 1'b0;
            r_rd_addr_q <= 4'h0;
            r_dbout     <= 8'h00;
            r_dboe      <= 1'b0;
        end else begin
            r_curr_addr <= w_curr_addr;
            r_curr_word <= w_curr_word;
            r_base_addr <= w_base_addr;
            r_base_word <= w_base_word;
            r_mode      <= w_mode;
            r_cmd       <= w_cmd;
            r_req       <= w_req;
            r_mask      <= w_mask;
            r_temp      <= w_temp;
            r_status    <= w_status;
            r_ff        <= w_ff;
            r_iow_n_q   <= IOW_N;
            r_rd_act_q  <= w_rd;
            r_rd_addr_q <= A;
            r_dbout     <= w_rd ? w_rd_data : 8'h00;
            r_dboe      <= w_rd;
        end
    end

    assign currAddrReg = r_curr_addr;
    assign currWordReg = r_curr_word;
    assign baseAddrReg = r_base_addr;
    assign baseWordReg = r_base_word;
    assign modeReg     = r_mode;
    assign commandReg  = r_cmd;
    assign requestReg  = r_req;
    assign maskReg     = r_mask;
    assign tempReg     = r_temp;
    assign statusReg   = r_status;
    assign DBOut       = r_dbout;
    assign DBOe        = r_dboe;

endmodule

// File: tb/tb_dma_reg_prog.sv
// tb/tb_dma_reg_prog.sv - self-checking bench for dma_reg_prog
module tb_dma_reg_prog;

    logic        CLK = 1'b0;
    logic        RESET, CS_N, IOR_N, IOW_N;
    logic [3:0]  A;
    logic [7:0]  DBIn, DBOut;
    logic        DBOe;
    logic        updEn, reloadEn, tempLoad;
    logic [1:0]  updChan, reloadChan;
    logic [15:0] updAddr, updWord;
    logic [3:0]  tc, dreq;
    logic [7:0]  tempIn;
    logic [15:0] currAddrReg [0:3];
    logic [15:0] currWordReg [0:3];
    logic [15:0] baseAddrReg [0:3];
    logic [15:0] baseWordReg [0:3];
    logic [5:0]  modeReg     [0:3];
    logic [7:0]  commandReg, requestReg, maskReg, tempReg, statusReg;

    always #5 CLK = ~CLK;

    dma_reg_prog dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A(A), .DBIn(DBIn), .DBOut(DBOut), .DBOe(DBOe),
        .updEn(updEn), .updChan(updChan), .updAddr(updAddr), .updWord(updWord),
        .reloadEn(reloadEn), .reloadChan(reloadChan), .tc(tc), .dreq(dreq),
        .tempLoad(tempLoad), .tempIn(tempIn),
        .currAddrReg(currAddrReg), .currWordReg(currWordReg),
        .baseAddrReg(baseAddrReg), .baseWordReg(baseWordReg), .modeReg(modeReg),
        .commandReg(commandReg), .requestReg(requestReg), .maskReg(maskReg),
        .tempReg(tempReg), .statusReg(statusReg)
    );

    localparam int C_CA1 = 0, C_BA1 = 1, C_BW1 = 2, C_CW1 = 3;
    localparam int C_CMD = 4, C_REQ = 5, C_MASK = 6, C_NONE = 7;
    localparam int NV = 22;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [7:0]  data;
        int          chk;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        string      name;
    } sb_t;

    vec_t vecs [0:NV-1];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] get_reg(input int c);
        case (c)
            C_CA1:   return currAddrReg[1];
            C_BA1:   return baseAddrReg[1];
            C_BW1:   return baseWordReg[1];
            C_CW1:   return currWordReg[1];
            C_CMD:   return {8'h00, commandReg};
            C_REQ:   return {8'h00, requestReg};
            C_MASK:  return {8'h00, maskReg};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
        CS_N = 1'b0; IOW_N = 1'b0; A = addr; DBIn = data;
        @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic cpu_read(input logic [3:0] addr, input logic [7:0] exp, input string name);
        sb_t e;
        sb.push_back('{exp, name});
        CS_N = 1'b0; IOR_N = 1'b0; A = addr;
        @(negedge CLK);
        e = sb.pop_front();
        check({e.name, "_oe"}, 16'(DBOe), 16'h0001);
        check(e.name, 16'(DBOut), 16'(e.data));
        CS_N = 1'b1; IOR_N = 1'b1;
        @(negedge CLK);
        check({e.name, "_oe_off"}, 16'(DBOe), 16'h0000);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0; DBIn = 8'h00;
        updEn = 1'b0; updChan = 2'd0; updAddr = 16'h0; updWord = 16'h0;
        reloadEn = 1'b0; reloadChan = 2'd0; tc = 4'h0; dreq = 4'h0;
        tempLoad = 1'b0; tempIn = 8'h00;

        vecs[0]  = '{1'b1, 4'h2, 8'h34, C_CA1,  16'h0034};
        vecs[1]  = '{1'b1, 4'h2, 8'h12, C_BA1,  16'h1234};
        vecs[2]  = '{1'b1, 4'h2, 8'h56, C_CA1,  16'h1256};
        vecs[3]  = '{1'b1, 4'h2, 8'h78, C_CA1,  16'h7856};
        vecs[4]  = '{1'b0, 4'h2, 8'h00, C_NONE, 16'h0056};
        vecs[5]  = '{1'b0, 4'h2, 8'h00, C_NONE, 16'h0078};
        vecs[6]  = '{1'b1, 4'h3, 8'hCD, C_BW1,  16'h00CD};
        vecs[7]  = '{1'b1, 4'h3, 8'hAB, C_CW1,  16'hABCD};
        vecs[8]  = '{1'b0, 4'h3, 8'h00, C_NONE, 16'h00CD};
        vecs[9]  = '{1'b0, 4'h3, 8'h00, C_NONE, 16'h00AB};
        vecs[10] = '{1'b1, 4'h8, 8'h5A, C_CMD,  16'h005A};
        vecs[11] = '{1'b1, 4'h9, 8'h06, C_REQ,  16'h0004};
        vecs[12] = '{1'b1, 4'h9, 8'h07, C_REQ,  16'h000C};
        vecs[13] = '{1'b1, 4'h9, 8'h03, C_REQ,  16'h0004};
        vecs[14] = '{1'b1, 4'hF, 8'hFA, C_MASK, 16'h000A};
        vecs[15] = '{1'b1, 4'hA, 8'h04, C_MASK, 16'h000B};
        vecs[16] = '{1'b1, 4'hE, 8'h00, C_MASK, 16'h0000};
        vecs[17] = '{1'b0, 4'hD, 8'h00, C_NONE, 16'h0000};
        vecs[18] = '{1'b0, 4'hB, 8'h00, C_NONE, 16'h0000};
        vecs[19] = '{1'b0, 4'h8, 8'h00, C_NONE, 16'h0000};
        vecs[20] = '{1'b1, 4'h9, 8'hFC, C_REQ,  16'h0005};
        vecs[21] = '{1'b1, 4'hF, 8'hFF, C_MASK, 16'h000F};

        @(negedge CLK);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_curr_addr%0d", k), currAddrReg[k], 16'h0000);
            check($sformatf("rst_base_word%0d", k), baseWordReg[k], 16'h0000);
            check($sformatf("rst_mode%0d", k), 16'(modeReg[k]), 16'h0000);
        end
        check("rst_mask", 16'(maskReg), 16'h000F);
        check("rst_status", 16'(statusReg), 16'h0000);
        check("rst_dboe", 16'(DBOe), 16'h0000);
        check("rst_dbout", 16'(DBOut), 16'h0000);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].data);
                check($sformatf("vec%0d_wr_a%0h", i, vecs[i].addr), get_reg(vecs[i].chk), vecs[i].exp);
            end else begin
                cpu_read(vecs[i].addr, vecs[i].exp[7:0], $sformatf("vec%0d_rd_a%0h", i, vecs[i].addr));
            end
        end

        // Long write strobe: one commit only
        CS_N = 1'b0; IOW_N = 1'b0; A = 4'h0; DBIn = 8'hFF;
        repeat (5) @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1;
        @(negedge CLK);
        check("held_wr_curr0", currAddrReg[0], 16'h00FF);
        check("held_wr_base0", baseAddrReg[0], 16'h00FF);
        cpu_write(4'h0, 8'h11);
        check("held_wr_ff_hi", currAddrReg[0], 16'h11FF);

        // CPU write coinciding with updEn on the same channel
        CS_N = 1'b0; IOW_N = 1'b0; A = 4'h4; DBIn = 8'h9C;
        updEn = 1'b1; updChan = 2'd2; updAddr = 16'hBEEF; updWord = 16'h1357;
        @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1; updEn = 1'b0;
        @(negedge CLK);
        check("coll_curr_addr2", currAddrReg[2], 16'hBE9C);
        check("coll_curr_word2", currWordReg[2], 16'h1357);
        check("coll_base_addr2", baseAddrReg[2], 16'h009C);
        cpu_write(4'hC, 8'h00);
        cpu_write(4'h4, 8'h77);
        check("ff_clear_cmd", currAddrReg[2], 16'hBE77);
        cpu_write(4'hC, 8'h00);

        // updEn / reloadEn interplay
        updEn = 1'b1; updChan = 2'd1; updAddr = 16'h1111; updWord = 16'h2222;
        @(negedge CLK);
        updEn = 1'b0;
        check("upd_curr_addr1", currAddrReg[1], 16'h1111);
        check("upd_curr_word1", currWordReg[1], 16'h2222);
        reloadEn = 1'b1; reloadChan = 2'd1;
        updEn = 1'b1; updChan = 2'd3; updAddr = 16'h3333; updWord = 16'h4444;
        @(negedge CLK);
        reloadEn = 1'b0; updEn = 1'b0;
        check("reload_curr_addr1", currAddrReg[1], 16'h7856);
        check("reload_curr_word1", currWordReg[1], 16'hABCD);
        check("upd_curr_addr3", currAddrReg[3], 16'h3333);
        check("upd_curr_word3", currWordReg[3], 16'h4444);
        reloadEn = 1'b1; reloadChan = 2'd3;
        updEn = 1'b1; updChan = 2'd3; updAddr = 16'h5555; updWord = 16'h6666;
        @(negedge CLK);
        reloadEn = 1'b0; updEn = 1'b0;
        check("reload_wins_addr3", currAddrReg[3], 16'h0000);
        check("reload_wins_word3", currWordReg[3], 16'h0000);

        // Status: tc sticky bits, dreq mirror, clear on read end
        dreq = 4'b0100; tc = 4'b0001;
        @(negedge CLK);
        tc = 4'b0000;
        @(negedge CLK);
        check("status_set", 16'(statusReg), 16'h0041);
        cpu_read(4'h8, 8'h41, "status_rd");
        check("status_clr", 16'(statusReg), 16'h0040);
        CS_N = 1'b0; IOR_N = 1'b0; A = 4'h8;
        @(negedge CLK);
        CS_N = 1'b1; IOR_N = 1'b1; tc = 4'b0010;
        @(negedge CLK);
        tc = 4'b0000;
        check("status_tc_wins", 16'(statusReg), 16'h0042);
        tempLoad = 1'b1; tempIn = 8'hC3;
        @(negedge CLK);
        tempLoad = 1'b0;
        cpu_read(4'hD, 8'hC3, "temp_rd");

        // All strobes low: nothing happens
        CS_N = 1'b0; IOR_N = 1'b0; IOW_N = 1'b0; A = 4'h0; DBIn = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("all_low_oe%0d", k), 16'(DBOe), 16'h0000);
        end
        CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
        @(negedge CLK);
        check("all_low_curr0", currAddrReg[0], 16'h11FF);
        cpu_write(4'h0, 8'h22);
        check("all_low_ff", currAddrReg[0], 16'h1122);
        cpu_write(4'hC, 8'h00);

        // Reset during a held write strobe must not commit afterwards
        RESET = 1'b0; CS_N = 1'b0; IOW_N = 1'b0; A = 4'h8; DBIn = 8'h99;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1;
        @(negedge CLK);
        check("rst_abort_cmd", 16'(commandReg), 16'h0000);
        check("rst2_mask", 16'(maskReg), 16'h000F);
        check("rst2_curr0", currAddrReg[0], 16'h0000);
        check("rst2_status", 16'(statusReg), 16'h0040);

        // Mode/mask writes then master clear
        cpu_write(4'hB, 8'h07);
        check("mode3_wr", 16'(modeReg[3]), 16'h0001);
        cpu_write(4'hA, 8'h05);
        check("mask_bit1", 16'(maskReg), 16'h000F);
        cpu_write(4'h8, 8'h33);
        check("cmd_wr", 16'(commandReg), 16'h0033);
        cpu_write(4'h0, 8'hAA);
        tempLoad = 1'b1; tempIn = 8'h5E;
        @(negedge CLK);
        tempLoad = 1'b0;
        check("temp_load", 16'(tempReg), 16'h005E);
        CS_N = 1'b0; IOW_N = 1'b0; A = 4'hD; DBIn = 8'h00; tempLoad = 1'b1; tempIn = 8'h99;
        @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1; tempLoad = 1'b0;
        @(negedge CLK);
        check("mc_mode3", 16'(modeReg[3]), 16'h0001);
        check("mc_mask", 16'(maskReg), 16'h000F);
        check("mc_cmd", 16'(commandReg), 16'h0000);
        check("mc_temp", 16'(tempReg), 16'h0000);
        check("mc_curr0", currAddrReg[0], 16'h00AA);
        cpu_write(4'h0, 8'hBB);
        check("mc_ff", currAddrReg[0], 16'h00BB);

        check("sb_empty", 16'(sb.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
